audio_dist: RTL and testbench

AUDIO_DIST -- requirements
Module: audio_dist

---
 rtl/audio_dist.sv | 85 ++++++++
 tb/tb_audio_dist.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dist.sv
// Four-channel audio distortion/volume stage: polynomial noise counters,
// per-channel waveform flip-flops, high-pass latches and volume gating.
module audio_dist (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enn,
    input  logic [3:0]  bor,
    input  logic [7:0]  D,
    input  logic [3:0]  WR,
    input  logic        init,
    input  logic        poly9,
    input  logic        hp1,
    input  logic        hp2,
    output logic [3:0]  chOut,
    output logic [15:0] vol
);

    logic [3:0][7:0] audc;
    logic [3:0]      poly4;
    logic [4:0]      poly5;
    logic [16:0]     poly17;
    logic [3:0]      ff;
    logic            hq0;
    logic            hq1;

    logic p4_out;
    logic p5_out;
    logic p17_out;

    assign p4_out  = poly4[3];
    assign p5_out  = poly5[4];
    // The 9-bit mode reuses the low bits of the 17-bit register, so toggling
    // poly9 never disturbs the stored state.
    assign p17_out = poly9 ? poly17[8] : poly17[16];

    always_ff @(negedge clk) begin
        if (!nreset) begin
            audc   <= '0;
            poly4  <= '0;
            poly5  <= '0;
            poly17 <= '0;
            ff     <= '0;
            hq0    <= 1'b0;
            hq1    <= 1'b0;
        end else if (enn) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (bor[n] && (audc[n][7] || p5_out)) begin
                    if (audc[n][5])
                        ff[n] <= ~ff[n];
                    else
                        ff[n] <= audc[n][6] ? p4_out : p17_out;
                end
                if (WR[n])
                    audc[n] <= D;
            end
            if (bor[2])
                hq0 <= ff[0];
            if (bor[3])
                hq1 <= ff[1];
            if (init) begin
                poly4  <= '0;
                poly5  <= '0;
                poly17 <= '0;
            end else begin
                poly4  <= {poly4[2:0], ~(poly4[3] ^ poly4[2])};
                poly5  <= {poly5[3:0], ~(poly5[4] ^ poly5[2])};
                poly17 <= {poly17[15:0],
                           poly9 ? ~(poly17[8] ^ poly17[4]) : ~(poly17[16] ^ poly17[13])};
            end
        end
    end

    always_comb begin
        chOut[0] = ff[0] ^ (hp1 & hq0);
        chOut[1] = ff[1] ^ (hp2 & hq1);
        chOut[2] = ff[2];
        chOut[3] = ff[3];
        vol      = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            if (audc[n][4] || chOut[n])
                vol[4*n +: 4] = audc[n][3:0];
        end
    end

endmodule

// File: tb/tb_audio_dist.sv
// Directed self-checking bench for audio_dist: tone, volume-only, noise
// counter periods, high-pass, write/borrow collision and reset behaviour.
module tb_audio_dist;

    logic        clk;
    logic        nreset;
    logic        enn;
    logic [3:0]  bor;
    logic [7:0]  D;
    logic [3:0]  WR;
    logic        init;
    logic        poly9;
    logic        hp1;
    logic        hp2;
    logic [3:0]  chOut;
    logic [15:0] vol;

    int tests = 0;
    int fails = 0;

    audio_dist dut (
        .clk   (clk),
        .nreset(nreset),
        .enn   (enn),
        .bor   (bor),
        .D     (D),
        .WR    (WR),
        .init  (init),
        .poly9 (poly9),
        .hp1   (hp1),
        .hp2   (hp2),
        .chOut (chOut),
        .vol   (vol)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs settle on the falling edge; sample 1 time unit later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        WR     = '0;
        bor    = '0;
        step();
        nreset = 1'b1;
    endtask

    bit c0 [1022];
    bit c1 [1022];
    bit c3 [1022];
    bit p5 [62];

    initial begin
        logic        exp_t;
        logic        m_ff0, m_ff2, m_hq0, nhq;
        logic        b0, b2;
        logic [8:0]  v5;
        logic [7:0]  v4;
        logic [9:0]  v9;
        logic        c0_hold;
        int          mis, ones;

        nreset = 1'b0; enn = 1'b1; bor = '0; D = '0; WR = '0;
        init = 1'b0; poly9 = 1'b0; hp1 = 1'b0; hp2 = 1'b0;

        // Reset must win over simultaneous writes and borrows.
        WR = 4'hF; D = 8'h1F; bor = 4'hF;
        step();
        check("reset_chout", chOut, 0);
        check("reset_vol", vol, 0);

        // Pure tone on channel 0, borrow every 4 cycles.
        nreset = 1'b1; WR = 4'b0001; D = 8'hA8; bor = '0;
        step();
        WR = '0;
        check("tone_init_ch", chOut[0], 0);
        check("tone_init_vol", vol[3:0], 0);
        exp_t = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 4; c++) begin
                bor[0] = (c == 3);
                step();
                if (c == 3) exp_t = ~exp_t;
                if (c == 1 || c == 3) begin
                    check("tone_ch0", chOut[0], exp_t);
                    check("tone_vol0", vol[3:0], exp_t ? 4'h8 : 4'h0);
                end
            end
        end
        bor = '0;

        // Volume-only on channel 2.
        WR = 4'b0100; D = 8'h1F;
        step();
        WR = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("volonly_vol2", vol[11:8], 4'hF);
            check("volonly_ch2", chOut[2], 0);
        end

        // High-pass: ch0 filtered by ch2, borrows at 3:1 with one coincidence.
        do_reset();
        hp1 = 1'b1;
        WR = 4'b0001; D = 8'hA4; step();
        WR = 4'b0100; D = 8'hA0; step();
        WR = '0;
        m_ff0 = 1'b0; m_ff2 = 1'b0; m_hq0 = 1'b0;
        for (int k = 0; k < 18; k++) begin
            b0 = (k % 2 == 0);
            b2 = (k % 6 == 4);
            bor = {1'b0, b2, 1'b0, b0};
            step();
            nhq = b2 ? m_ff0 : m_hq0;
            if (b0) m_ff0 = ~m_ff0;
            if (b2) m_ff2 = ~m_ff2;
            m_hq0 = nhq;
            check("hp_ch0", chOut[0], m_ff0 ^ m_hq0);
            check("hp_ch2", chOut[2], m_ff2);
            check("hp_vol0", vol[3:0], (m_ff0 ^ m_hq0) ? 4'h4 : 4'h0);
        end
        bor = '0; hp1 = 1'b0;
        step();
        check("hp_off_ch0", chOut[0], m_ff0);

        // Write coinciding with borrow: old AUDC 0x00 (poly5 gate open, poly17=0).
        do_reset();
        for (int i = 0; i < 5; i++) step();
        WR = 4'b0010; D = 8'hA5; bor = 4'b0010;
        step();
        WR = '0;
        check("collide_ch1", chOut[1], 0);
        check("collide_vol1", vol[7:4], 0);
        step();
        bor = '0;
        check("after_collide_ch1", chOut[1], 1);
        check("after_collide_vol1", vol[7:4], 4'h5);

        // Polynomial counters: ch0 toggles gated by poly5, ch1 loads poly9, ch3 loads poly4.
        init = 1'b1;
        do_reset();
        WR = 4'b0001; D = 8'h20; step();
        WR = 4'b0010; D = 8'h80; step();
        WR = 4'b1000; D = 8'hC0; step();
        WR = '0;
        poly9 = 1'b1; init = 1'b0; bor = 4'b1011;
        for (int k = 0; k < 1022; k++) begin
            step();
            c0[k] = chOut[0];
            c1[k] = chOut[1];
            c3[k] = chOut[3];
        end
        for (int k = 0; k < 62; k++)
            p5[k] = c0[k] ^ ((k == 0) ? 1'b0 : c0[k-1]);

        for (int i = 0; i < 9; i++) v5[i] = p5[i];
        check("poly5_start", v5, 9'h0E0);
        mis = 0; ones = 0;
        for (int k = 0; k < 31; k++) begin
            if (p5[k] != p5[k+31]) mis++;
            if (p5[k]) ones++;
        end
        check("poly5_period", mis, 0);
        check("poly5_ones", ones, 15);

        for (int i = 0; i < 8; i++) v4[i] = c3[i];
        check("poly4_start", v4, 8'h70);
        mis = 0; ones = 0;
        for (int k = 0; k < 15; k++) begin
            if (c3[k] != c3[k+15]) mis++;
            if (c3[k]) ones++;
        end
        check("poly4_period", mis, 0);
        check("poly4_ones", ones, 7);

        for (int i = 0; i < 10; i++) v9[i] = c1[i];
        check("poly9_start", v9, 10'h200);
        mis = 0; ones = 0;
        for (int k = 0; k < 511; k++) begin
            if (c1[k] != c1[k+511]) mis++;
            if (c1[k]) ones++;
        end
        check("poly9_period", mis, 0);
        check("poly9_ones", ones, 255);

        // init=1 holds counters at zero: loads give 0, poly5 gate stays shut.
        init = 1'b1;
        step();
        c0_hold = chOut[0];
        step();
        step();
        check("init_ch1", chOut[1], 0);
        check("init_ch3", chOut[3], 0);
        check("init_ch0_hold", chOut[0], c0_hold);

        // Releasing init restarts the sequences from the all-zero state.
        init = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            v9[i] = chOut[1];
            if (i < 8) v4[i] = chOut[3];
        end
        check("poly9_restart", v9, 10'h200);
        check("poly4_restart", v4, 8'h70);

        // enn=0 freezes state; reset still applies with enn=0.
        bor = '0; poly9 = 1'b0;
        WR = 4'b0100; D = 8'h1F; step();
        WR = '0;
        check("pre_vol2", vol[11:8], 4'hF);
        enn = 1'b0; WR = 4'b0100; D = 8'h00; bor = 4'hF;
        step();
        check("enn_hold_vol2", vol[11:8], 4'hF);
        nreset = 1'b0;
        step();
        check("reset_noenn_chout", chOut, 0);
        check("reset_noenn_vol", vol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
